// File: rtl/alu_arb_pkg.sv
// Shared definitions for the SemiCPU ALU arbiter: opcode encodings and FSM state type.
package alu_arb_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOOP0 = 3'b000;
    localparam logic [OP_W-1:0] OP_NOOP1 = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD   = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB   = 3'b011;
    localparam logic [OP_W-1:0] OP_SHL   = 3'b100;
    localparam logic [OP_W-1:0] OP_SHR   = 3'b101;
    localparam logic [OP_W-1:0] OP_ADDI  = 3'b110;
    localparam logic [OP_W-1:0] OP_SUBI  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic logic is_noop(input logic [OP_W-1:0] op);
        return (op == OP_NOOP0) || (op == OP_NOOP1);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr+1, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            // ptr+k never exceeds 2*NUM_REQ-1, so one conditional subtract is a full modulo
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            cand = sum[ID_W-1:0];
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// Optional ALU_ARB_NOOP_BYPASS_EN: NOOP opcodes skip the ALU cycle and answer with zero.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [OP_W-1:0]           alu_opcode,
    input  logic [DATA_W-1:0]         alu_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy
);

    arb_state_t          state;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     op_id;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                any_grant;
    logic                accept;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [OP_W-1:0]     sel_op;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx),
        .found (any_grant)
    );

    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign accept    = (state == IDLE) && any_grant;

    assign sel_a  = req_a[grant_idx*DATA_W +: DATA_W];
    assign sel_b  = req_b[grant_idx*DATA_W +: DATA_W];
    assign sel_op = req_op[grant_idx*OP_W +: OP_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= ID_W'(NUM_REQ-1);
            op_id      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ptr   <= grant_idx;
                        op_id <= grant_idx;
                        busy  <= 1'b1;
`ifdef ALU_ARB_NOOP_BYPASS_EN
                        if (is_noop(sel_op)) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_id    <= grant_idx;
                            rsp_data  <= '0;
                        end else begin
                            state      <= EXEC;
                            alu_a      <= sel_a;
                            alu_b      <= sel_b;
                            alu_opcode <= sel_op;
                        end
`else
                        state      <= EXEC;
                        alu_a      <= sel_a;
                        alu_b      <= sel_b;
                        alu_opcode <= sel_op;
`endif
                    end
                end
                // ALU inputs are held for exactly this cycle; capture its result at the edge
                EXEC: begin
                    state      <= RESP;
                    rsp_valid  <= 1'b1;
                    rsp_data   <= alu_result;
                    rsp_id     <= op_id;
                    alu_a      <= '0;
                    alu_b      <= '0;
                    alu_opcode <= '0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU model attached.
module tb_alu_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a = '0;
    logic [NUM_REQ*DATA_W-1:0] req_b = '0;
    logic [NUM_REQ*3-1:0]      req_op = '0;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic [2:0]                alu_opcode;
    logic [DATA_W-1:0]         alu_result;
    logic                      rsp_valid;
    logic                      rsp_ready = 1'b0;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      busy;

    int passed = 0;
    int total  = 0;

    alu_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .ID_W    (ID_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the SemiCPU ALU
    always_comb begin
        case (alu_opcode)
            3'b010, 3'b110: alu_result = alu_a + alu_b;
            3'b011, 3'b111: alu_result = alu_a - alu_b;
            3'b100:         alu_result = alu_a << alu_b[4:0];
            3'b101:         alu_result = alu_a >> alu_b[4:0];
            default:        alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        req_a[i*DATA_W +: DATA_W] = a;
        req_b[i*DATA_W +: DATA_W] = b;
        req_op[i*3 +: 3]          = op;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};

        // Reset: req_ready must stay low while rst is high, even with requests pending
        rst = 1'b1;
        req_valid = 4'hF;
        step();
        step();
        #1;
        chk("ready_in_rst", 64'(req_ready), 64'h0);
        req_valid = '0;
        step();
        rst = 1'b0;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_id", 64'(rsp_id), 64'h0);
        chk("rst_rsp_data", 64'(rsp_data), 64'h0);
        chk("rst_alu_a", 64'(alu_a), 64'h0);
        chk("rst_alu_b", 64'(alu_b), 64'h0);
        chk("rst_alu_op", 64'(alu_opcode), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);

        // Single ADD from requester 2: 7 + 5 = 12
        set_req(2, 32'd7, 32'd5, 3'b010);
        req_valid = 4'b0100;
        #1;
        chk("t1_ready", 64'(req_ready), 64'h4);
        step();
        req_valid = '0;
        #1;
        chk("t1_alu_a", 64'(alu_a), 64'd7);
        chk("t1_alu_b", 64'(alu_b), 64'd5);
        chk("t1_alu_op", 64'(alu_opcode), 64'h2);
        chk("t1_no_valid_yet", 64'(rsp_valid), 64'h0);
        chk("t1_busy", 64'(busy), 64'h1);
        step();
        chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t1_rsp_id", 64'(rsp_id), 64'h2);
        chk("t1_rsp_data", 64'(rsp_data), 64'd12);
        chk("t1_alu_idle", 64'(alu_opcode), 64'h0);
        rsp_ready = 1'b1;
        step();
        chk("t1_back_idle", 64'(busy), 64'h0);
        chk("t1_valid_low", 64'(rsp_valid), 64'h0);

        // Reset again, then all four requesters valid: rotation 0,1,2,3,0
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, 32'(i + 10), 32'(i), 3'b010);
        end
        req_valid = 4'hF;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk($sformatf("rr%0d_ready", n), 64'(req_ready), 64'(1 << order[n]));
            step();
            step();
            chk($sformatf("rr%0d_valid", n), 64'(rsp_valid), 64'h1);
            chk($sformatf("rr%0d_id", n), 64'(rsp_id), 64'(order[n]));
            chk($sformatf("rr%0d_data", n), 64'(rsp_data), 64'(2 * order[n] + 10));
            step();
        end
        req_valid = '0;

        // SHL 1 << 4 = 16 with rsp_ready held low for 5 cycles
        rsp_ready = 1'b0;
        set_req(1, 32'd1, 32'd4, 3'b100);
        req_valid = 4'b0010;
        #1;
        chk("t3_ready", 64'(req_ready), 64'h2);
        step();
        set_req(2, 32'd3, 32'd3, 3'b010);
        req_valid = 4'b1101;
        step();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t3_hold%0d_valid", c), 64'(rsp_valid), 64'h1);
            chk($sformatf("t3_hold%0d_data", c), 64'(rsp_data), 64'd16);
            chk($sformatf("t3_hold%0d_busy", c), 64'(busy), 64'h1);
            chk($sformatf("t3_hold%0d_ready", c), 64'(req_ready), 64'h0);
            if (c < 4) step();
        end
        rsp_ready = 1'b1;
        step();
        #1;
        chk("t3_next_accept", 64'(req_ready), 64'h4);
        step();
        chk("t3_exec_op", 64'(alu_opcode), 64'h2);

        // Reset in EXEC: operation dropped, pointer back to N-1
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = '0;
        #1;
        chk("t4_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("t4_alu_a", 64'(alu_a), 64'h0);
        chk("t4_alu_op", 64'(alu_opcode), 64'h0);
        chk("t4_busy", 64'(busy), 64'h0);
        chk("t4_rsp_data", 64'(rsp_data), 64'h0);
        step();
        chk("t4_still_no_rsp", 64'(rsp_valid), 64'h0);
        req_valid = 4'hF;
        #1;
        chk("t4_ptr_reset", 64'(req_ready), 64'h1);
        req_valid = '0;
        #1;

        // NOOP opcode 001 from requester 0
        set_req(0, 32'd9, 32'd9, 3'b001);
        req_valid = 4'b0001;
        #1;
        chk("t5_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = '0;
`ifdef ALU_ARB_NOOP_BYPASS_EN
        chk("t5_fast_valid", 64'(rsp_valid), 64'h1);
        chk("t5_fast_data", 64'(rsp_data), 64'h0);
        chk("t5_alu_quiet", 64'(alu_opcode), 64'h0);
        chk("t5_alu_a_quiet", 64'(alu_a), 64'h0);
`else
        chk("t5_not_yet", 64'(rsp_valid), 64'h0);
        chk("t5_alu_op", 64'(alu_opcode), 64'h1);
        step();
        chk("t5_valid", 64'(rsp_valid), 64'h1);
        chk("t5_data", 64'(rsp_data), 64'h0);
`endif
        step();
        chk("t5_idle", 64'(rsp_valid), 64'h0);

        // SUB 0 - 1 wraps to all ones
        set_req(3, 32'd0, 32'd1, 3'b011);
        req_valid = 4'b1000;
        #1;
        chk("t6_ready", 64'(req_ready), 64'h8);
        step();
        req_valid = '0;
        step();
        chk("t6_valid", 64'(rsp_valid), 64'h1);
        chk("t6_id", 64'(rsp_id), 64'h3);
        chk("t6_data", 64'(rsp_data), 64'hFFFF_FFFF);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
